// File: rtl/buff_pkg.sv
// Shared types and defaults for the buff_rx line receiver.
//   state_t      : qualification FSM states
//   *_D          : default parameter values
//   qcnt_width() : width of the qualification counter for a given DEBOUNCE
package buff_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int SYNC_STAGES_D = 2;
  localparam int DEBOUNCE_D    = 4;
  localparam int CNT_W_D       = 8;

  // The counter only has to reach DEBOUNCE-1, but it never shrinks below 1 bit.
  function automatic int qcnt_width(input int debounce);
    return (debounce <= 2) ? 1 : $clog2(debounce);
  endfunction

endpackage

// File: rtl/buff_rx_if.sv
// Signal bundle between a raw line source and the buff_rx receiver.
//   b        : raw asynchronous line (source -> receiver)
//   x_stable : debounced level
//   rise     : 1-cycle pulse on an accepted 0->1 change
//   fall     : 1-cycle pulse on an accepted 1->0 change
//   busy     : a candidate change is being qualified
//   edge_cnt : wrapping count of accepted changes
// master = line source / consumer of the results, slave = buff_rx.
interface buff_rx_if
  import buff_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
);
  logic             b;
  logic             x_stable;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output b,
    input  x_stable, rise, fall, busy, edge_cnt
  );

  modport slave (
    input  b,
    output x_stable, rise, fall, busy, edge_cnt
  );
endinterface

// File: rtl/buff_rx_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/buff_rx.sv
// Receive side of the 1-bit line buffer: synchronizes b, debounces it with a
// consecutive-sample counter, and reports accepted changes as pulses and a count.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : buff_rx_if slave (b in; x_stable, rise, fall, busy, edge_cnt out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// STABLE  | synced line agrees with x_stable, nothing being qualified
// PENDING | synced line differs; qcnt counts consecutive differing samples
module buff_rx
  import buff_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DEBOUNCE    = DEBOUNCE_D,
  parameter int CNT_W       = CNT_W_D
) (
  input logic        clk,
  input logic        rst,
  buff_rx_if.slave   bus
);

  localparam int            QW     = qcnt_width(DEBOUNCE);
  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE - 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);

  logic             s;
  state_t           state;
  logic [QW-1:0]    qcnt;
  logic             x_stable;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;
  logic             differ;
  logic             accept;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.b),
    .q   (s)
  );

  assign differ = s ^ x_stable;

  // With DEBOUNCE==1 the first differing sample is already the whole window.
  assign accept = differ &&
                  (((state == STABLE) && (DEBOUNCE == 1)) ||
                   ((state == PENDING) && (qcnt == Q_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STABLE;
      qcnt     <= '0;
      x_stable <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (accept) begin
        x_stable <= s;
        qcnt     <= '0;
        state    <= STABLE;
        busy     <= 1'b0;
        rise     <= s;
        fall     <= ~s;
        edge_cnt <= edge_cnt + 1'b1;
      end else begin
        unique case (state)
          STABLE: begin
            if (differ) begin
              qcnt  <= Q_ONE;
              state <= PENDING;
              busy  <= 1'b1;
            end else begin
              qcnt <= '0;
            end
          end
          PENDING: begin
            if (!differ) begin
              qcnt  <= '0;
              state <= STABLE;
              busy  <= 1'b0;
            end else begin
              qcnt <= qcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.x_stable = x_stable;
  assign bus.rise     = rise;
  assign bus.fall     = fall;
  assign bus.busy     = busy;
  assign bus.edge_cnt = edge_cnt;

endmodule
